ram_seq_ctrl: RTL and testbench

- Record/playback sequencer for the 32x4 single-port block RAM used by the board exercises.
- Debounces two push buttons: a mode button and a step button.
- In RECORD, each step press writes the switch value din to the next RAM address.
- In PLAY, the recorded entries are read back cyclically at a timed rate, and a step press skips ahead. The block drives the RAM's addra/dina/wea and captures douta.

---
 rtl/ram_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_seq_ctrl.sv
// Record/playback sequencer for a 32x4 single-port block RAM.
// Two debounced buttons select IDLE/RECORD/PLAY and step through RAM entries.
module ram_seq_ctrl #(
  parameter int unsigned CMAX = 1249999,
  parameter int unsigned PDIV = 50,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_mode,
  input  logic          btn_step,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wea,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] dout,
  output logic [1:0]    mode,
  output logic [AW:0]   count,
  output logic          full
);

  localparam int unsigned CW = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
  localparam int unsigned PW = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam logic [CW-1:0] CLast = CW'(CMAX);
  localparam logic [PW-1:0] PLast = PW'(PDIV - 1);
  localparam logic [AW:0]   Depth = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRecord = 2'b01,
    StPlay   = 2'b10
  } state_e;

  logic [CW-1:0] div_q;
  logic          tick, tick_d1_q;
  logic          mcur_q, mprev_q, scur_q, sprev_q;
  logic          mode_pls, step_pls;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_wea_q, ram_wea_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          adv, last;

  assign tick = (div_q == CLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      tick_d1_q <= 1'b0;
      mcur_q    <= 1'b0;
      mprev_q   <= 1'b0;
      scur_q    <= 1'b0;
      sprev_q   <= 1'b0;
    end else begin
      div_q     <= tick ? '0 : div_q + 1'b1;
      tick_d1_q <= tick;
      if (tick) begin
        mcur_q  <= btn_mode;
        mprev_q <= mcur_q;
        scur_q  <= btn_step;
        sprev_q <= scur_q;
      end
    end
  end

  // A mode press always wins over a coincident step press.
  assign mode_pls = tick_d1_q & mcur_q & ~mprev_q;
  assign step_pls = tick_d1_q & scur_q & ~sprev_q & ~mode_pls;
  assign full     = (count_q == Depth);
  assign last     = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    pcnt_d     = pcnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wea_d  = 1'b0;
    dout_d     = dout_q;
    adv        = 1'b0;

    // The write cycle retires here, even if the mode changes in the same cycle.
    if (ram_wea_q && !full) count_d = count_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        ram_addr_d = '0;
        if (mode_pls) begin
          state_d = StRecord;
          count_d = '0;
        end
      end
      StRecord: begin
        if (mode_pls) begin
          ram_addr_d = '0;
          if (count_q != '0 || ram_wea_q) begin
            state_d  = StPlay;
            rd_ptr_d = '0;
            pcnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (step_pls && !full) begin
          ram_wea_d  = 1'b1;
          ram_addr_d = count_q[AW-1:0];
          ram_din_d  = din;
        end
      end
      StPlay: begin
        dout_d     = ram_dout;
        ram_addr_d = rd_ptr_q;
        if (tick) begin
          if (pcnt_q == PLast) begin
            pcnt_d = '0;
            adv    = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        if (step_pls) adv = 1'b1;
        if (adv) rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
        if (mode_pls) begin
          state_d    = StIdle;
          ram_addr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      pcnt_q     <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wea_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      pcnt_q     <= pcnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wea_q  <= ram_wea_d;
      dout_q     <= dout_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_wea  = ram_wea_q;
  assign dout     = dout_q;
  assign mode     = state_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a small RAM model and a write-pulse log.
module tb_ram_seq_ctrl;

  logic       clk, rst, btn_mode, btn_step, ram_wea, full;
  logic [3:0] din, ram_din, ram_dout, dout;
  logic [4:0] ram_addr;
  logic [1:0] mode;
  logic [5:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  ram_seq_ctrl #(.CMAX(3), .PDIV(2), .AW(5), .DW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_step (btn_step),
    .din      (din),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_wea  (ram_wea),
    .ram_dout (ram_dout),
    .dout     (dout),
    .mode     (mode),
    .count    (count),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: douta is valid the cycle after addra is registered.
  logic [3:0] mem [32];
  always @(posedge clk) if (ram_wea) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  // Cycle counter tracking the debounce divider phase.
  int bcyc = 0;
  always @(posedge clk) bcyc <= rst ? 0 : bcyc + 1;

  int         log_n = 0;
  logic [4:0] log_a [64];
  logic [3:0] log_d [64];
  always @(negedge clk) begin
    if (ram_wea) begin
      if (log_n < 64) begin
        log_a[log_n] <= ram_addr;
        log_d[log_n] <= ram_din;
      end
      log_n <= log_n + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    cyc(10);
  endtask

  task automatic press_step(input logic [3:0] d);
    din      = d;
    btn_step = 1'b1;
    cyc(10);
    btn_step = 1'b0;
    cyc(10);
  endtask

  logic [4:0] a_log [80];
  logic [3:0] d_log [80];
  logic [1:0] m_log [80];

  initial begin
    int base;
    int p;
    int found;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_step = 1'b0;
    din      = 4'h0;

    // Reset
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_mode", mode, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dout", dout, 0);

    // Record two entries
    base = log_n;
    press_mode();
    chk("rec_mode", mode, 2'b01);
    press_step(4'hA);
    press_step(4'h5);
    chk("rec_nwr", log_n - base, 2);
    chk("rec_wr0", {log_a[base], log_d[base]}, {5'd0, 4'hA});
    chk("rec_wr1", {log_a[base+1], log_d[base+1]}, {5'd1, 4'h5});
    chk("rec_count", count, 2);
    chk("rec_mode2", mode, 2'b01);

    // Playback: sample each cycle, step press injected mid-period
    p = -1;
    btn_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a_log[i] = ram_addr;
      d_log[i] = dout;
      m_log[i] = mode;
      if (p < 0 && mode == 2'b10) p = i;
      if (i == 12) btn_mode = 1'b0;
      if (p >= 0 && i == p + 32) btn_step = 1'b1;
      if (p >= 0 && i == p + 44) btn_step = 1'b0;
      cyc(1);
    end
    btn_step = 1'b0;
    chk("play_entry", 32'(p >= 0 && p < 36), 1);
    if (p < 0 || p >= 36) p = 0;
    chk("play_mode", m_log[p], 2'b10);
    chk("play_a0", a_log[p], 0);
    chk("play_d0", d_log[p+1], 4'hA);
    chk("play_a7", a_log[p+7], 0);
    chk("play_a8", a_log[p+8], 1);
    chk("play_d8", d_log[p+8], 4'hA);
    chk("play_d9", d_log[p+9], 4'h5);
    chk("play_a15", a_log[p+15], 1);
    chk("play_a16", a_log[p+16], 0);
    chk("play_d17", d_log[p+17], 4'hA);
    chk("play_a23", a_log[p+23], 0);
    chk("play_a24", a_log[p+24], 1);
    chk("play_d25", d_log[p+25], 4'h5);
    chk("step_a36", a_log[p+36], 0);
    chk("step_a37", a_log[p+37], 1);
    chk("step_d38", d_log[p+38], 4'h5);
    chk("step_a40", a_log[p+40], 0);
    cyc(20);
    press_mode();
    chk("idle_mode", mode, 2'b00);
    chk("idle_addr", ram_addr, 0);

    // Glitch shorter than a debounce period, then fill the RAM
    press_mode();
    chk("rec2_mode", mode, 2'b01);
    chk("rec2_count", count, 0);
    base = log_n;
    for (int i = 0; i < 8 && (bcyc % 4) != 0; i++) cyc(1);
    btn_step = 1'b1;
    cyc(2);
    btn_step = 1'b0;
    cyc(12);
    chk("glitch_nwr", log_n - base, 0);
    chk("glitch_count", count, 0);
    base = log_n;
    for (int i = 0; i < 32; i++) press_step(4'(i * 3));
    chk("fill_nwr", log_n - base, 32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("fill_wr%0d", k), {log_a[base+k], log_d[base+k]}, {5'(k), 4'(k * 3)});
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);
    press_step(4'hF);
    chk("over_nwr", log_n - base, 32);
    chk("over_count", count, 32);
    chk("over_full", full, 1);

    // Empty RECORD exits to IDLE; mode beats step
    press_mode();
    chk("full_play", mode, 2'b10);
    press_mode();
    press_mode();
    chk("empty_count", count, 0);
    press_mode();
    chk("empty_idle", mode, 2'b00);
    press_mode();
    press_step(4'h7);
    chk("one_count", count, 1);
    base = log_n;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    cyc(10);
    chk("both_mode", mode, 2'b10);
    chk("both_nwr", log_n - base, 0);
    chk("both_count", count, 1);
    press_mode();

    // Reset during a write cycle
    press_mode();
    din      = 4'h9;
    btn_step = 1'b1;
    found    = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ram_wea) found = 1;
      else cyc(1);
    end
    chk("wea_seen", found, 1);
    rst      = 1'b1;
    btn_step = 1'b0;
    cyc(1);
    chk("rstw_wea", ram_wea, 0);
    chk("rstw_mode", mode, 2'b00);
    chk("rstw_count", count, 0);
    chk("rstw_addr", ram_addr, 0);
    chk("rstw_dout", dout, 0);
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
